// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the MIPS pipeline control unit: opcodes, functs, ALU codes,
// selector enums, the ID/EX control word and its bubble value.
package pipe_ctrl_pkg;

    localparam int CTRL_AC_W = 5;

    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDI   = 6'h08;
    localparam logic [5:0] OP_SLTI   = 6'h0a;
    localparam logic [5:0] OP_ANDI   = 6'h0c;
    localparam logic [5:0] OP_ORI    = 6'h0d;
    localparam logic [5:0] OP_XORI   = 6'h0e;
    localparam logic [5:0] OP_MUL    = 6'h1c;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2b;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;
    localparam logic [5:0] FN_SLT = 6'h2a;

    localparam logic [CTRL_AC_W-1:0] AC_AND = 5'd0;
    localparam logic [CTRL_AC_W-1:0] AC_ADD = 5'd1;
    localparam logic [CTRL_AC_W-1:0] AC_SUB = 5'd2;
    localparam logic [CTRL_AC_W-1:0] AC_MUL = 5'd3;
    localparam logic [CTRL_AC_W-1:0] AC_OR  = 5'd4;
    localparam logic [CTRL_AC_W-1:0] AC_NOR = 5'd5;
    localparam logic [CTRL_AC_W-1:0] AC_XOR = 5'd6;
    localparam logic [CTRL_AC_W-1:0] AC_SLL = 5'd7;
    localparam logic [CTRL_AC_W-1:0] AC_SRL = 5'd8;
    localparam logic [CTRL_AC_W-1:0] AC_SLT = 5'd9;
    localparam logic [CTRL_AC_W-1:0] AC_J   = 5'd16;

    typedef enum logic [1:0] {SRC_REG = 2'd0, SRC_IMM = 2'd1, SRC_SHAMT = 2'd2} alu_src_e;
    typedef enum logic [1:0] {JR_REG = 2'd0, JR_JUMP = 2'd1, JR_SEQ = 2'd2} jr_sel_e;
    typedef enum logic [1:0] {SZ_WORD = 2'd0, SZ_HALF = 2'd1, SZ_BYTE = 2'd2} mem_sz_e;
    typedef enum logic {ST_RUN = 1'b0, ST_MUL_BUSY = 1'b1} state_e;

    typedef struct packed {
        logic                 reg_dst;
        logic                 branch;
        logic                 mem_read;
        logic                 mem_to_reg;
        logic                 mem_write;
        logic                 reg_write;
        logic                 shift;
        logic                 jal;
        alu_src_e             alu_src;
        logic [CTRL_AC_W-1:0] ac;
        jr_sel_e              jr_sel;
        mem_sz_e              ld_sz;
        mem_sz_e              st_sz;
    } ctrl_t;

    localparam ctrl_t BUBBLE = '{reg_dst: 1'b0, branch: 1'b0, mem_read: 1'b0,
                                 mem_to_reg: 1'b0, mem_write: 1'b0, reg_write: 1'b0,
                                 shift: 1'b0, jal: 1'b0, alu_src: SRC_REG, ac: 5'd0,
                                 jr_sel: JR_SEQ, ld_sz: SZ_WORD, st_sz: SZ_WORD};

endpackage

// File: rtl/pipe_ctrl_unit_decode.sv
// Combinational main decoder: opcode/funct to ID/EX control word, plus whether the
// instruction sources Rt (needed for load-use detection).
module ctrl_decode
    import pipe_ctrl_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [4:0] rt,
    output ctrl_t      ctrl,
    output logic       reads_rt
);

    // Decode table; anything unrecognised stays a bubble
    always_comb begin
        ctrl     = BUBBLE;
        reads_rt = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                reads_rt       = 1'b1;
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                case (funct)
                    FN_ADD: ctrl.ac = AC_ADD;
                    FN_SUB: ctrl.ac = AC_SUB;
                    FN_AND: ctrl.ac = AC_AND;
                    FN_OR:  ctrl.ac = AC_OR;
                    FN_NOR: ctrl.ac = AC_NOR;
                    FN_XOR: ctrl.ac = AC_XOR;
                    FN_SLT: ctrl.ac = AC_SLT;
                    FN_SRL: begin
                        ctrl.shift   = 1'b1;
                        ctrl.alu_src = SRC_SHAMT;
                        ctrl.ac      = AC_SRL;
                    end
                    // sll $0,$0,0 is the canonical NOP
                    FN_SLL: begin
                        if (rt == 5'd0) begin
                            ctrl     = BUBBLE;
                            reads_rt = 1'b0;
                        end else begin
                            ctrl.shift   = 1'b1;
                            ctrl.alu_src = SRC_SHAMT;
                            ctrl.ac      = AC_SLL;
                        end
                    end
                    FN_JR: begin
                        ctrl        = BUBBLE;
                        ctrl.jr_sel = JR_REG;
                        ctrl.ac     = AC_J;
                        reads_rt    = 1'b0;
                    end
                    default: begin
                        ctrl     = BUBBLE;
                        reads_rt = 1'b0;
                    end
                endcase
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI: begin
                ctrl.alu_src    = SRC_IMM;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                case (opcode)
                    OP_SLTI: ctrl.ac = AC_SLT;
                    OP_ANDI: ctrl.ac = AC_AND;
                    OP_ORI:  ctrl.ac = AC_OR;
                    OP_XORI: ctrl.ac = AC_XOR;
                    default: ctrl.ac = AC_ADD;
                endcase
            end
            OP_LB, OP_LH, OP_LW: begin
                ctrl.alu_src   = SRC_IMM;
                ctrl.ac        = AC_ADD;
                ctrl.mem_read  = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.ld_sz     = (opcode == OP_LB) ? SZ_BYTE :
                                 (opcode == OP_LH) ? SZ_HALF : SZ_WORD;
            end
            OP_SB, OP_SH, OP_SW: begin
                reads_rt       = 1'b1;
                ctrl.alu_src   = SRC_IMM;
                ctrl.ac        = AC_ADD;
                ctrl.mem_write = 1'b1;
                ctrl.st_sz     = (opcode == OP_SB) ? SZ_BYTE :
                                 (opcode == OP_SH) ? SZ_HALF : SZ_WORD;
            end
            OP_J, OP_JAL: begin
                ctrl.jr_sel    = JR_JUMP;
                ctrl.ac        = AC_J;
                ctrl.jal       = (opcode == OP_JAL);
                ctrl.reg_write = (opcode == OP_JAL);
            end
            OP_BEQ, OP_BNE: begin
                reads_rt    = 1'b1;
                ctrl.branch = 1'b1;
                ctrl.ac     = AC_SUB;
            end
            OP_BLEZ, OP_BGTZ: begin
                ctrl.branch = 1'b1;
                ctrl.ac     = AC_SUB;
            end
            // REGIMM with rt==0 is bltz; other REGIMM forms are unsupported
            OP_REGIMM: begin
                if (rt == 5'd0) begin
                    ctrl.branch = 1'b1;
                    ctrl.ac     = AC_SUB;
                end else begin
                    ctrl = BUBBLE;
                end
            end
            OP_MUL: begin
                reads_rt        = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.ac         = AC_MUL;
            end
            default: begin
                ctrl     = BUBBLE;
                reads_rt = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Registered decode plus stall/flush sequencer for the 5-stage MIPS pipeline.
// Define CTRL_PERF_EN to add saturating stall/flush performance counters.
module pipe_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int AC_W    = 5,
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic            Clk,
    input  logic            Rst_n,
    input  logic [5:0]      Opcode,
    input  logic [5:0]      Funct,
    input  logic [4:0]      Rs,
    input  logic [4:0]      Rt,
    input  logic            IdExMemRead,
    input  logic [4:0]      IdExRt,
    input  logic            MemRedirect,
    output logic            RegDst,
    output logic            Branch,
    output logic            MemRead,
    output logic            MemToReg,
    output logic            MemWrite,
    output logic            RegWrite,
    output logic            Shift,
    output logic            Jal,
    output logic [1:0]      AluSrc,
    output logic [AC_W-1:0] Ac,
    output logic [1:0]      JrSel,
    output logic [1:0]      LdSz,
    output logic [1:0]      StSz,
    output logic            PcWrite,
    output logic            IfIdWrite,
    output logic            IdExHold,
    output logic            FlushIfId,
    output logic            FlushExMem,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    localparam int MCNT_W = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;

    state_e            state_r, state_s;
    logic [MCNT_W-1:0] mcnt_r, mcnt_s;
    ctrl_t             ctrl_r, ctrl_s;
    ctrl_t             dec_ctrl_s;
    logic              dec_reads_rt_s;
    logic              load_use_s;

    ctrl_decode u_decode (
        .opcode   (Opcode),
        .funct    (Funct),
        .rt       (Rt),
        .ctrl     (dec_ctrl_s),
        .reads_rt (dec_reads_rt_s)
    );

    assign load_use_s = (state_r == ST_RUN) && IdExMemRead && (IdExRt != 5'd0) &&
                        ((IdExRt == Rs) || ((IdExRt == Rt) && dec_reads_rt_s));

    // Priority: reset, MEM redirect, MUL hold, load-use stall, normal decode
    always_comb begin
        state_s    = state_r;
        mcnt_s     = mcnt_r;
        ctrl_s     = ctrl_r;
        PcWrite    = 1'b1;
        IfIdWrite  = 1'b1;
        IdExHold   = 1'b0;
        FlushIfId  = 1'b0;
        FlushExMem = 1'b0;
        if (!Rst_n) begin
            PcWrite    = 1'b0;
            IfIdWrite  = 1'b0;
            FlushIfId  = 1'b1;
            FlushExMem = 1'b1;
            ctrl_s     = BUBBLE;
            state_s    = ST_RUN;
            mcnt_s     = {MCNT_W{1'b0}};
        end else if (MemRedirect) begin
            // the held mul is younger than the redirecting branch, so it dies too
            FlushIfId  = 1'b1;
            FlushExMem = 1'b1;
            ctrl_s     = BUBBLE;
            state_s    = ST_RUN;
            mcnt_s     = {MCNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_MUL_BUSY: begin
                    PcWrite    = 1'b0;
                    IfIdWrite  = 1'b0;
                    IdExHold   = 1'b1;
                    FlushExMem = 1'b1;
                    if (mcnt_r == {MCNT_W{1'b0}}) begin
                        state_s = ST_RUN;
                    end else begin
                        mcnt_s = mcnt_r - 1'b1;
                    end
                end
                ST_RUN: begin
                    if (load_use_s) begin
                        PcWrite   = 1'b0;
                        IfIdWrite = 1'b0;
                        ctrl_s    = BUBBLE;
                    end else begin
                        ctrl_s = dec_ctrl_s;
                        if ((dec_ctrl_s.ac == AC_MUL) && (MUL_LAT > 1)) begin
                            state_s = ST_MUL_BUSY;
                            mcnt_s  = MCNT_W'(MUL_LAT - 2);
                        end else begin
                            state_s = ST_RUN;
                        end
                    end
                end
                default: begin
                    state_s = ST_RUN;
                    ctrl_s  = BUBBLE;
                end
            endcase
        end
    end

    // State, MUL countdown and ID/EX control register
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_r <= ST_RUN;
            mcnt_r  <= {MCNT_W{1'b0}};
            ctrl_r  <= BUBBLE;
        end else begin
            state_r <= state_s;
            mcnt_r  <= mcnt_s;
            ctrl_r  <= ctrl_s;
        end
    end

    assign RegDst   = ctrl_r.reg_dst;
    assign Branch   = ctrl_r.branch;
    assign MemRead  = ctrl_r.mem_read;
    assign MemToReg = ctrl_r.mem_to_reg;
    assign MemWrite = ctrl_r.mem_write;
    assign RegWrite = ctrl_r.reg_write;
    assign Shift    = ctrl_r.shift;
    assign Jal      = ctrl_r.jal;
    assign AluSrc   = ctrl_r.alu_src;
    assign Ac       = AC_W'(ctrl_r.ac);
    assign JrSel    = ctrl_r.jr_sel;
    assign LdSz     = ctrl_r.ld_sz;
    assign StSz     = ctrl_r.st_sz;

`ifdef CTRL_PERF_EN
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] flush_cnt_r;

    // Saturating stall and redirect counters
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (!PcWrite && (stall_cnt_r != {CNT_W{1'b1}})) begin
                stall_cnt_r <= stall_cnt_r + 1'b1;
            end
            if (MemRedirect && (flush_cnt_r != {CNT_W{1'b1}})) begin
                flush_cnt_r <= flush_cnt_r + 1'b1;
            end
        end
    end

    assign StallCnt = stall_cnt_r;
    assign FlushCnt = flush_cnt_r;
`else
    assign StallCnt = {CNT_W{1'b0}};
    assign FlushCnt = {CNT_W{1'b0}};
`endif

endmodule
